// File: rtl/shake_pkg.sv
// Shared constants, state encoding and byte-mask helpers for the SHAKE256 input padder.
package shake_pkg;

  localparam int         RATE_BITS       = 1088;
  localparam int         RATE_BYTES      = 136;
  localparam int         LANES_PER_BLOCK = 17;
  localparam logic [7:0] DOMAIN_SUFFIX   = 8'h1F;
  localparam logic [7:0] PAD_FINAL       = 8'h80;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    HOLD = 2'd2
  } pad_state_e;

  // Byte counts above a full word are illegal upstream and saturate to eight.
  function automatic logic [3:0] clamp_bytes(input logic [3:0] nbytes);
    return (nbytes > 4'd8) ? 4'd8 : nbytes;
  endfunction

  function automatic logic [63:0] last_word_mask(input logic [3:0] nbytes);
    logic [3:0]  n;
    logic [63:0] m;
    n = clamp_bytes(nbytes);
    m = 64'd0;
    for (int k = 0; k < 8; k++) begin
      m[8*k +: 8] = (4'(k) < n) ? 8'hFF : 8'h00;
    end
    return m;
  endfunction

endpackage

// File: rtl/shake_pad_inject.sv
// Combinational pad injection: XORs the domain suffix at byte_pos and the
// final pad bit into the last rate byte (both coincide at byte 135 -> 0x9F).
module shake_pad_inject
  import shake_pkg::*;
(
  input  logic [RATE_BITS-1:0] block_in,
  input  logic [7:0]           byte_pos,
  output logic [RATE_BITS-1:0] block_out
);

  for (genvar i = 0; i < RATE_BYTES; i++) begin : g_byte
    localparam logic [7:0] FINAL_BYTE = (i == RATE_BYTES - 1) ? PAD_FINAL : 8'h00;
    assign block_out[8*i +: 8] = block_in[8*i +: 8]
                               ^ ((byte_pos == 8'(i)) ? DOMAIN_SUFFIX : 8'h00)
                               ^ FINAL_BYTE;
  end

endmodule

// File: rtl/shake_padder.sv
// SHAKE256 input stage: packs 64-bit words into 1088-bit rate blocks and pads the
// final one. Optional block_count output enabled by SHAKE_PADDER_BLOCK_COUNT_EN.
module shake_padder #(
  parameter int RATE_BITS = 1088,
  parameter int WORD_BITS = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WORD_BITS-1:0] in_data,
  input  logic [3:0]           in_bytes,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [RATE_BITS-1:0] block_data,
  output logic [10:0]          block_length,
  output logic                 block_valid,
  output logic                 block_last,
`ifdef SHAKE_PADDER_BLOCK_COUNT_EN
  output logic [15:0]          block_count,
`endif
  input  logic                 out_ready
);
  import shake_pkg::*;

  localparam logic [4:0] LAST_LANE = 5'(LANES_PER_BLOCK - 1);

  pad_state_e           state_r;
  pad_state_e           state_next_s;
  logic [RATE_BITS-1:0] buf_r;
  logic [RATE_BITS-1:0] padded_s;
  logic [4:0]           word_idx_r;
  logic [7:0]           byte_pos_r;
  logic                 pad_pending_r;
  logic [10:0]          block_length_r;
  logic                 block_last_r;
  logic                 accept_s;
  logic                 take_s;
  logic [WORD_BITS-1:0] lane_s;
  logic [7:0]           last_pos_s;

  assign accept_s   = (state_r == FILL) && in_valid;
  assign take_s     = (state_r == HOLD) && out_ready;
  assign lane_s     = in_last ? (in_data & last_word_mask(in_bytes)) : in_data;
  assign last_pos_s = {word_idx_r, 3'b000} + {4'b0000, clamp_bytes(in_bytes)};

  shake_pad_inject u_inject (
    .block_in  (buf_r),
    .byte_pos  (byte_pos_r),
    .block_out (padded_s)
  );

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FILL: begin
        if (accept_s && in_last) begin
          state_next_s = PAD;
        end else if (accept_s && (word_idx_r == LAST_LANE)) begin
          state_next_s = HOLD;
        end else begin
          state_next_s = FILL;
        end
      end
      PAD:  state_next_s = HOLD;
      HOLD: begin
        if (take_s) begin
          state_next_s = pad_pending_r ? PAD : FILL;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: state_next_s = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= FILL;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Block buffer, counters and block descriptor.
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_r          <= '0;
      word_idx_r     <= 5'd0;
      byte_pos_r     <= 8'd0;
      pad_pending_r  <= 1'b0;
      block_length_r <= 11'd0;
      block_last_r   <= 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          if (accept_s) begin
            for (int i = 0; i < LANES_PER_BLOCK; i++) begin
              if (word_idx_r == 5'(i)) begin
                buf_r[WORD_BITS*i +: WORD_BITS] <= lane_s;
              end
            end
            if (in_last) begin
              byte_pos_r <= last_pos_s;
            end else if (word_idx_r == LAST_LANE) begin
              block_length_r <= 11'(RATE_BITS);
              block_last_r   <= 1'b0;
            end else begin
              word_idx_r <= word_idx_r + 5'd1;
            end
          end
        end
        PAD: begin
          if (byte_pos_r < 8'(RATE_BYTES)) begin
            buf_r          <= padded_s;
            block_length_r <= {byte_pos_r, 3'b000};
            block_last_r   <= 1'b1;
          end else begin
            // Message ended exactly on a block boundary: padding goes in a block of its own.
            block_length_r <= 11'(RATE_BITS);
            block_last_r   <= 1'b0;
            pad_pending_r  <= 1'b1;
          end
        end
        HOLD: begin
          if (take_s) begin
            buf_r      <= '0;
            word_idx_r <= 5'd0;
            if (pad_pending_r) begin
              pad_pending_r <= 1'b0;
              byte_pos_r    <= 8'd0;
            end
          end
        end
        default: begin
          buf_r <= '0;
        end
      endcase
    end
  end

  assign in_ready     = (state_r == FILL);
  assign block_valid  = (state_r == HOLD);
  assign block_data   = buf_r;
  assign block_length = block_length_r;
  assign block_last   = block_last_r;

`ifdef SHAKE_PADDER_BLOCK_COUNT_EN
  logic [15:0] block_count_r;

  // Blocks handed off since reset or since the last block of the previous message.
  always_ff @(posedge clock) begin
    if (reset) begin
      block_count_r <= 16'd0;
    end else if (take_s) begin
      block_count_r <= block_last_r ? 16'd0 : block_count_r + 16'd1;
    end else begin
      block_count_r <= block_count_r;
    end
  end

  assign block_count = block_count_r;
`endif

endmodule

// File: tb/tb_shake_padder.sv
// Randomised bench for shake_padder: byte-level padding model, per-cycle compare
// process, and directed cases with literal expectations.
`timescale 1ns/1ps
module tb_shake_padder;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [1087:0] data;
    logic [10:0]   len;
    logic          last;
  } blk_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [63:0]   in_data = 64'd0;
  logic [3:0]    in_bytes = 4'd0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [1087:0] block_data;
  logic [10:0]   block_length;
  logic          block_valid;
  logic          block_last;
  logic          out_ready = 1'b0;
`ifdef SHAKE_PADDER_BLOCK_COUNT_EN
  logic [15:0]   block_count;
  int            exp_cnt = 0;
`endif

  blk_t exp_q[$];
  blk_t got_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   exp_rise = -1;
  logic hold_off = 1'b0;
  logic prev_valid = 1'b0;

  shake_padder dut (
    .clock        (clock),
    .reset        (reset),
    .in_data      (in_data),
    .in_bytes     (in_bytes),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .block_data   (block_data),
    .block_length (block_length),
    .block_valid  (block_valid),
    .block_last   (block_last),
`ifdef SHAKE_PADDER_BLOCK_COUNT_EN
    .block_count  (block_count),
`endif
    .out_ready    (out_ready)
  );

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk_blk(input string name, input logic [1087:0] act, input logic [1087:0] exp);
    int idx;
    checks++;
    if (act !== exp) begin
      errors++;
      idx = 0;
      for (int k = 135; k >= 0; k--) begin
        if (act[8*k +: 8] !== exp[8*k +: 8]) idx = k;
      end
      $display("FAIL %s: byte %0d got %02h expected %02h (cycle %0d)",
               name, idx, act[8*idx +: 8], exp[8*idx +: 8], cyc);
    end
  endfunction

  // Standard SHAKE padding over the whole message, cut into 136-byte blocks.
  function automatic void push_expected(input bq_t msg);
    int   len_b;
    int   nb;
    int   cnt;
    blk_t b;
    len_b = msg.size();
    nb    = len_b / 136 + 1;
    for (int j = 0; j < nb; j++) begin
      b.data = '0;
      cnt    = (j < nb - 1) ? 136 : (len_b - 136 * j);
      for (int k = 0; k < cnt; k++) b.data[8*k +: 8] = msg[136*j + k];
      b.last = (j == nb - 1);
      if (b.last) begin
        b.data[8*cnt +: 8]  = b.data[8*cnt +: 8] ^ 8'h1F;
        b.data[1080 +: 8]   = b.data[1080 +: 8] ^ 8'h80;
      end
      b.len = 11'(cnt * 8);
      exp_q.push_back(b);
    end
  endfunction

  function automatic bq_t rand_msg(input int n);
    bq_t m;
    for (int k = 0; k < n; k++) m.push_back(8'($urandom_range(0, 255)));
    return m;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the word was taken.
  task automatic send_word(input logic [63:0] d, input logic [3:0] nb, input logic last, input bit lane16);
    int gap;
    int waited;
    gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clock);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_bytes = nb;
    in_last  = last;
    waited   = 0;
    forever begin
      @(negedge clock);
      if (in_ready) begin
        if (last) exp_rise = cyc + 2;
        else if (lane16) exp_rise = cyc + 1;
        break;
      end
      waited++;
      if (waited > 400) begin
        chk("accept_timeout", 64'(waited), 64'd0);
        break;
      end
      @(posedge clock);
      #1;
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_msg(input bq_t msg, input bit extra_empty);
    int          len_b;
    int          nonlast;
    int          pos;
    int          rem_b;
    logic [63:0] d;
    logic [3:0]  nb;
    len_b = msg.size();
    push_expected(msg);
    pos = 0;
    if (len_b == 0) begin
      send_word({$urandom, $urandom}, 4'd0, 1'b1, 1'b0);
    end else begin
      nonlast = ((len_b % 8) != 0 || extra_empty) ? len_b / 8 : len_b / 8 - 1;
      for (int w = 0; w < nonlast; w++) begin
        for (int k = 0; k < 8; k++) d[8*k +: 8] = msg[pos + k];
        send_word(d, 4'($urandom_range(0, 15)), 1'b0, (w % 17) == 16);
        pos += 8;
      end
      d     = {$urandom, $urandom};
      rem_b = len_b - pos;
      for (int k = 0; k < rem_b; k++) d[8*k +: 8] = msg[pos + k];
      nb = (rem_b == 8 && $urandom_range(0, 1) == 1) ? 4'($urandom_range(9, 15)) : 4'(rem_b);
      send_word(d, nb, 1'b1, 1'b0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(posedge clock);
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!block_valid && n < 600) begin
      @(negedge clock);
      n++;
    end
    chk(name, 64'(block_valid), 64'd1);
  endtask

  // Downstream sink: random backpressure unless a test holds it off.
  initial forever begin
    @(posedge clock);
    #1;
    out_ready = hold_off ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Compare process: every presented block against the model queue.
  initial forever begin
    @(negedge clock);
    if (reset) begin
      prev_valid = 1'b0;
`ifdef SHAKE_PADDER_BLOCK_COUNT_EN
      exp_cnt = 0;
`endif
    end else begin
      chk("ready_with_valid", 64'(in_ready & block_valid), 64'd0);
      if (block_valid && !prev_valid && exp_rise >= 0) begin
        chk("valid_latency", 64'(cyc), 64'(exp_rise));
        exp_rise = -1;
      end
      prev_valid = block_valid;
      if (block_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_block", 64'(block_length), 64'h7FF);
        end else begin
          chk_blk("block_data", block_data, exp_q[0].data);
          chk("block_length", 64'(block_length), 64'(exp_q[0].len));
          chk("block_last", 64'(block_last), 64'(exp_q[0].last));
`ifdef SHAKE_PADDER_BLOCK_COUNT_EN
          chk("block_count", 64'(block_count), 64'(exp_cnt));
`endif
          if (out_ready) begin
            got_q.push_back('{block_data, block_length, block_last});
`ifdef SHAKE_PADDER_BLOCK_COUNT_EN
            exp_cnt = block_last ? 0 : ((exp_cnt + 1) % 65536);
`endif
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bq_t           msg;
    logic [1087:0] lit;
    logic [1087:0] snap;
    logic [63:0]   d;
    int            bl[8] = '{0, 1, 7, 8, 135, 136, 137, 272};
    int            len_b;

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_block_valid", 64'(block_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_block_length", 64'(block_length), 64'd0);
    chk("rst_block_last", 64'(block_last), 64'd0);
    chk_blk("rst_block_data", block_data, '0);
    @(posedge clock);
    #1;

    // Empty message
    got_q.delete();
    msg = rand_msg(0);
    send_msg(msg, 1'b0);
    drain();
    chk("empty_nblocks", 64'(got_q.size()), 64'd1);
    if (got_q.size() >= 1) begin
      lit = '0;
      lit[7:0] = 8'h1F;
      lit[1087:1080] = 8'h80;
      chk_blk("empty_data", got_q[0].data, lit);
      chk("empty_len", 64'(got_q[0].len), 64'd0);
      chk("empty_last", 64'(got_q[0].last), 64'd1);
    end

    // Three bytes AA BB CC
    got_q.delete();
    msg = '{8'hAA, 8'hBB, 8'hCC};
    send_msg(msg, 1'b0);
    drain();
    chk("three_nblocks", 64'(got_q.size()), 64'd1);
    if (got_q.size() >= 1) begin
      lit = '0;
      lit[31:0] = 32'h1FCCBBAA;
      lit[1087:1080] = 8'h80;
      chk_blk("three_data", got_q[0].data, lit);
      chk("three_len", 64'(got_q[0].len), 64'd24);
    end

    // 135 bytes: both pad bytes share byte 135
    got_q.delete();
    msg = rand_msg(135);
    send_msg(msg, 1'b0);
    drain();
    chk("b135_nblocks", 64'(got_q.size()), 64'd1);
    if (got_q.size() >= 1) begin
      lit = got_q[0].data;
      chk("b135_byte", 64'(lit[1087:1080]), 64'h9F);
      chk("b135_len", 64'(got_q[0].len), 64'd1080);
      chk("b135_last", 64'(got_q[0].last), 64'd1);
    end

    // 136 bytes: full block then a padding-only block
    got_q.delete();
    msg = rand_msg(136);
    send_msg(msg, 1'b0);
    drain();
    chk("b136_nblocks", 64'(got_q.size()), 64'd2);
    if (got_q.size() >= 2) begin
      chk("b136_a_len", 64'(got_q[0].len), 64'd1088);
      chk("b136_a_last", 64'(got_q[0].last), 64'd0);
      chk("b136_b_len", 64'(got_q[1].len), 64'd0);
      chk("b136_b_last", 64'(got_q[1].last), 64'd1);
      lit = got_q[1].data;
      chk("b136_b_byte0", 64'(lit[7:0]), 64'h1F);
    end

    // 200 bytes with the first block held for 10 cycles
    got_q.delete();
    hold_off = 1'b1;
    msg = rand_msg(200);
    fork
      send_msg(msg, 1'b0);
      begin
        wait_valid("hold_seen");
        snap = block_data;
        repeat (10) begin
          @(negedge clock);
          chk_blk("hold_stable", block_data, snap);
          chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clock);
        #1;
        hold_off = 1'b0;
      end
    join
    drain();
    chk("b200_nblocks", 64'(got_q.size()), 64'd2);
    if (got_q.size() >= 2) begin
      lit = got_q[1].data;
      chk("b200_len", 64'(got_q[1].len), 64'd512);
      chk("b200_byte64", 64'(lit[519:512]), 64'h1F);
    end

    // Reset while a full block is held mid-message
    hold_off = 1'b1;
    msg = rand_msg(200);
    push_expected(msg);
    void'(exp_q.pop_back());
    for (int w = 0; w < 17; w++) begin
      for (int k = 0; k < 8; k++) d[8*k +: 8] = msg[8*w + k];
      send_word(d, 4'd8, 1'b0, w == 16);
    end
    wait_valid("rsthold_seen");
    @(posedge clock);
    #1;
    reset = 1'b1;
    exp_q.delete();
    exp_rise = -1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rsthold_valid", 64'(block_valid), 64'd0);
    chk("rsthold_ready", 64'(in_ready), 64'd1);
    chk_blk("rsthold_data", block_data, '0);
    @(posedge clock);
    #1;
    hold_off = 1'b0;
    got_q.delete();
    msg = rand_msg(1);
    send_msg(msg, 1'b0);
    drain();
    chk("after_rst_nblocks", 64'(got_q.size()), 64'd1);
    if (got_q.size() >= 1) begin
      chk("after_rst_len", 64'(got_q[0].len), 64'd8);
      lit = got_q[0].data;
      chk("after_rst_byte1", 64'(lit[15:8]), 64'h1F);
    end

    // Random messages, biased toward block and word boundaries
    for (int t = 0; t < 40; t++) begin
      len_b = ($urandom_range(0, 3) == 0) ? bl[$urandom_range(0, 7)] : int'($urandom_range(0, 420));
      msg = rand_msg(len_b);
      send_msg(msg, $urandom_range(0, 2) == 0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shake_padder.md
# shake_padder

Upstream input stage of the SHAKE256 core. Accepts a byte-granular message as a stream of 64-bit words and packs it into 1088-bit rate blocks. Applies SHAKE padding (domain suffix 0x1F, final 0x80) and hands each block, with its message-bit length, to the absorb control via a valid/ready handshake. One block is buffered at a time.

## Interface

Parameters
- `RATE_BITS`, 1088: rate of SHAKE256; fixed.
- `WORD_BITS`, 64: input word width (one Keccak lane).

Ports
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_data` in 64: message word; byte k at bits [8k+7:8k].
- `in_bytes` in 4: valid bytes in word, 0..8. Sampled only with `in_last`; other words are always 8 bytes.
- `in_valid` in 1: word offered.
- `in_last` in 1: final word of message.
- `in_ready` out 1: word accepted when `in_valid && in_ready`.
- `block_data` out 1088: rate block; lane i at bits [64i+63:64i].
- `block_length` out 11: message bits carried in block, 0..1088.
- `block_valid` out 1: block presented.
- `block_last` out 1: block is final (padding included).
- `out_ready` in 1: downstream takes block when `block_valid && out_ready`.

## Operation

- States: FILL, PAD, HOLD. Counters: `word_idx` 0..16 (5 bits); `byte_pos` 0..136 (8 bits). Flag: `pad_pending`.
- FILL (`in_ready`=1): on accept, write `in_data` into lane `word_idx`, masked to the low `in_bytes` bytes if `in_last`.
  - Not last, `word_idx`<16: increment `word_idx`.
  - Not last, `word_idx`==16: go to HOLD with `block_length`=1088 and `block_last`=0.
  - Last: `byte_pos` = `word_idx`*8 + `in_bytes`; go to PAD.
- PAD (one cycle, `in_ready`=0):
  - If `byte_pos`<136: XOR 0x1F into byte `byte_pos` and 0x80 into byte 135. Set `block_length`=`byte_pos`*8 and `block_last`=1. Go to HOLD.
  - If `byte_pos`==136 (message fills block exactly): no padding. Set `block_length`=1088, `block_last`=0, set `pad_pending`. Go to HOLD.
- HOLD (`block_valid`=1, `in_ready`=0): outputs stable until `out_ready`. On handshake:
  - Clear buffer to 0, clear `word_idx`.
  - If `pad_pending`: clear it, set `byte_pos`=0, go to PAD. This produces a block containing only padding, with `block_length`=0 and `block_last`=1.
  - Else: go to FILL.
- `byte_pos`==135: both pad bytes land on byte 135, giving 0x9F.
- Empty message (`in_last`, `in_bytes`=0, `word_idx`=0): one block with 0x1F at byte 0, 0x80 at byte 135, `block_length`=0.
- `in_bytes`>8 with `in_last` is illegal; it is clamped to 8.
- Reset values: `block_data`=0, `block_length`=0, `block_valid`=0, `block_last`=0, `in_ready`=1 (state FILL), all counters and flags 0.
- Reset mid-operation: partial or held block discarded; next cycle is FILL with an empty buffer.

## Timing

- `in_ready` and `block_valid` are decoded from registered state only. There are no combinational paths from inputs to outputs.
- Throughput: one word per cycle in FILL.
- Latency:
  - 17th full word accepted at cycle N: `block_valid`=1 at N+1.
  - Last word accepted at N: PAD at N+1, `block_valid` at N+2.
- After the HOLD handshake at cycle M: `in_ready`=1 at M+1; or, with `pad_pending`, PAD at M+1 and `block_valid` at M+2.
- `in_valid` may rise or fall freely; the padder never drops an offered word.

## Configuration

- `SHAKE_PADDER_BLOCK_COUNT_EN` defined: adds output `block_count` (16 bits).
  - Increments on every block handshake and wraps at 65535→0.
  - Cleared by `reset` and on a handshake where `block_last`=1.
  - Value after clearing is 0.
- Macro undefined: port and counter absent; behaviour otherwise identical.

## Structure

- Package `shake_pkg`: `RATE_BITS`=1088, `RATE_BYTES`=136, `LANES_PER_BLOCK`=17, `DOMAIN_SUFFIX`=8'h1F, `PAD_FINAL`=8'h80, and the FILL/PAD/HOLD state enum.
- One combinational sub-module, `shake_pad_inject`: inputs are the block and `byte_pos`; output is the block with both pad bytes XORed in. Used only in PAD.

## Test plan

- Empty message (`in_last`, `in_bytes`=0) → one block: byte0=0x1F, byte135=0x80, rest 0, `block_length`=0, `block_last`=1.
- 3 bytes 0xAA,0xBB,0xCC in one last word → bytes 0..2 as given, byte3=0x1F, byte135=0x80, `block_length`=24.
- 135-byte message → byte135=0x9F, `block_length`=1080, `block_last`=1.
- 136-byte message → block A `block_length`=1088, `block_last`=0; block B padding only, `block_length`=0, `block_last`=1.
- 200-byte message with `out_ready` held low 10 cycles in HOLD → `block_data` stable, `in_ready`=0 throughout; block 2 has `block_length`=512 and byte 64=0x1F.
- `reset` asserted in HOLD mid-message → next cycle `block_valid`=0, `in_ready`=1; the following 1-byte message yields `block_length`=8.
